// File: rtl/hash_xor_serializer.sv
// Latches hash^target and streams it LSB-first into the downstream bits-off counter.
// Optional early abort against a best score: define HASH_XOR_EARLY_ABORT_EN.
module hash_xor_serializer #(
   parameter int HASH_WIDTH = 1024,
   parameter int IDX_WIDTH  = 10
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic                  hash_valid_i,
   input  logic [HASH_WIDTH-1:0] hash_i,
   input  logic [HASH_WIDTH-1:0] target_i,
`ifdef HASH_XOR_EARLY_ABORT_EN
   input  logic [IDX_WIDTH-1:0]  hash_bits_off_i,
   input  logic [IDX_WIDTH-1:0]  best_score_i,
   output logic                  aborted_o,
`endif
   output logic                  hash_ready_o,
   output logic                  count_reset_o,
   output logic                  add_o,
   output logic                  hash_xor_bit_o,
   output logic                  done_o,
   output logic                  busy_o
);

   typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

   state_t                state;
   logic [IDX_WIDTH-1:0]  idx;
   logic [HASH_WIDTH-1:0] xor_q;
   logic                  last;
   logic                  abort_hit;

   assign last = (idx == IDX_WIDTH'(HASH_WIDTH - 1));

`ifdef HASH_XOR_EARLY_ABORT_EN
   logic aborted_q;
   // Counter already at the threshold: stop before adding, so the count equals it exactly.
   assign abort_hit = (hash_bits_off_i >= best_score_i);
   assign aborted_o = (state == DONE) && aborted_q;
`else
   assign abort_hit = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state <= IDLE;
         idx   <= '0;
         xor_q <= '0;
`ifdef HASH_XOR_EARLY_ABORT_EN
         aborted_q <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (hash_valid_i) begin
                  xor_q <= hash_i ^ target_i;
                  idx   <= '0;
                  state <= CLEAR;
`ifdef HASH_XOR_EARLY_ABORT_EN
                  aborted_q <= 1'b0;
`endif
               end
            end
            CLEAR: state <= SHIFT;
            SHIFT: begin
               if (abort_hit) begin
                  state <= DONE;
`ifdef HASH_XOR_EARLY_ABORT_EN
                  aborted_q <= 1'b1;
`endif
               end else begin
                  xor_q <= xor_q >> 1;
                  idx   <= idx + 1'b1;
                  if (last) state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
`ifdef HASH_XOR_EARLY_ABORT_EN
               aborted_q <= 1'b0;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Reset also clears the downstream counter, so it tracks this block's state.
   assign count_reset_o  = !reset_ni || (state == CLEAR);
   assign hash_ready_o   = (state == IDLE);
   assign add_o          = (state == SHIFT) && !abort_hit;
   assign hash_xor_bit_o = (state == SHIFT) && xor_q[0];
   assign done_o         = (state == DONE);
   assign busy_o         = (state != IDLE);

endmodule

// File: tb/tb_hash_xor_serializer.sv
// Scoreboard bench: driver pushes model results at issue, negedge monitor checks the stream.
module tb_hash_xor_serializer;
   localparam int HW = 1024;
   localparam int IW = 10;

   logic          clk_i = 1'b0;
   logic          reset_ni = 1'b0;
   logic          hash_valid_i = 1'b0;
   logic [HW-1:0] hash_i = '0, target_i = '0;
   logic          hash_ready_o, count_reset_o, add_o, hash_xor_bit_o, done_o, busy_o;
   logic [IW-1:0] cnt = '0;
   logic [IW-1:0] best = '0;
`ifdef HASH_XOR_EARLY_ABORT_EN
   logic          aborted_o;
   localparam bit ABORT_EN = 1'b1;
`else
   localparam bit ABORT_EN = 1'b0;
`endif

   always #5 clk_i = ~clk_i;

   hash_xor_serializer #(.HASH_WIDTH(HW), .IDX_WIDTH(IW)) dut (
      .clk_i(clk_i), .reset_ni(reset_ni), .hash_valid_i(hash_valid_i),
      .hash_i(hash_i), .target_i(target_i),
`ifdef HASH_XOR_EARLY_ABORT_EN
      .hash_bits_off_i(cnt), .best_score_i(best), .aborted_o(aborted_o),
`endif
      .hash_ready_o(hash_ready_o), .count_reset_o(count_reset_o), .add_o(add_o),
      .hash_xor_bit_o(hash_xor_bit_o), .done_o(done_o), .busy_o(busy_o));

   // Downstream bits-off counter.
   always @(posedge clk_i)
      if (count_reset_o) cnt <= '0;
      else if (add_o)    cnt <= cnt + IW'(hash_xor_bit_o);

   typedef struct {
      logic [HW-1:0] x;
      int            adds;
      int            shifts;
      bit            ab;
      int            count;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   int   n_chk = 0, n_fail = 0;
   bit   inflight = 0, post_rst = 0;
   int   k = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, k, $time);
      end
   endtask

   // Walk the XOR bits in order, adding each to a running count; stop early once the
   // running (wrapped) count has reached the best score when abort is enabled.
   function automatic exp_t model(logic [HW-1:0] h, logic [HW-1:0] t, int b);
      exp_t e;
      int c = 0;
      e.x = h ^ t; e.adds = 0; e.ab = 0;
      for (int i = 0; i < HW; i++) begin
         if (ABORT_EN && (c % (1 << IW)) >= b) begin e.ab = 1; break; end
         c += int'(e.x[i]);
         e.adds++;
      end
      e.shifts = e.ab ? e.adds + 1 : HW;
      e.count  = c % (1 << IW);
      return e;
   endfunction

   function automatic logic [HW-1:0] rnd();
      logic [HW-1:0] r;
      for (int i = 0; i < HW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Monitor: decoupled from the driver, pops the expected record at each accept.
   always @(negedge clk_i) begin
      if (!reset_ni) begin
         chk("count_reset_in_reset", count_reset_o, 1);
         if (inflight) chk("no_done_in_reset", done_o, 0);
         inflight = 0;
         post_rst = 1;
      end else begin
         if (post_rst) begin
            chk("ready_after_reset", {hash_ready_o, busy_o, add_o, done_o}, 4'b1000);
            post_rst = 0;
         end
         if (inflight) begin
            k++;
            if (k == 1) begin
               chk("clear_cycle", {count_reset_o, add_o, busy_o, hash_ready_o, done_o}, 5'b10100);
            end else if (k < cur.shifts + 2) begin
               chk("add", add_o, (k - 2) < cur.adds);
               chk("xor_bit", hash_xor_bit_o, cur.x[k-2]);
               chk("shift_flags", {count_reset_o, busy_o, hash_ready_o, done_o}, 4'b0100);
            end else if (k == cur.shifts + 2) begin
               chk("done_cycle", {done_o, busy_o, add_o, hash_ready_o}, 4'b1100);
               chk("count", cnt, cur.count);
`ifdef HASH_XOR_EARLY_ABORT_EN
               chk("aborted", aborted_o, cur.ab);
`endif
            end else begin
               chk("idle_after_done", {hash_ready_o, busy_o, done_o}, 3'b100);
               inflight = 0;
            end
         end else begin
            chk("idle", {hash_ready_o, busy_o, add_o, done_o, count_reset_o}, 5'b10000);
`ifdef HASH_XOR_EARLY_ABORT_EN
            chk("aborted_idle", aborted_o, 0);
`endif
         end
         if (!inflight && hash_valid_i && hash_ready_o) begin
            if (q.size() == 0) begin
               chk("unexpected_accept", 1, 0);
               cur = model('0, '0, 0);
            end else cur = q.pop_front();
            inflight = 1;
            k = 0;
         end
      end
   end

   // Drive a candidate; returns one ns after its accept edge. hold keeps valid high.
   task automatic send(logic [HW-1:0] h, logic [HW-1:0] t, int b, bit hold);
      int w = 0;
      hash_i = h; target_i = t; best = IW'(b); hash_valid_i = 1'b1;
      q.push_back(model(h, t, b));
      @(negedge clk_i);
      while (!hash_ready_o) begin
         @(negedge clk_i);
         if (++w > 5000) begin chk("accept_timeout", 0, 1); hash_valid_i = 1'b0; return; end
      end
      @(posedge clk_i);
      #1;
      if (!hold) hash_valid_i = 1'b0;
      hash_i = rnd(); target_i = rnd();
   endtask

   initial begin
      logic [HW-1:0] a, b;
      int wt;
      repeat (2) @(posedge clk_i);
      #1 reset_ni = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      a = rnd();
      send(a, a, 0, 0);                                    // identical: count 0
      send({128{8'hA5}}, {128{8'h0F}}, 3, 0);              // alternating 0,1 stream
      a = rnd();
      send(a, ~a, 1023, 0);                                // all differ: count wraps to 0
      a = '0; a[HW-1] = 1'b1;
      send(a, '0, 1, 0);                                   // single bit on the last position
      // Reset in cycle 5 of a stream: candidate dropped, no done.
      send(rnd(), rnd(), 600, 0);
      repeat (4) @(posedge clk_i);
      #1 reset_ni = 1'b0;
      @(posedge clk_i);
      #1 reset_ni = 1'b1;
      // Valid held high across two candidates with the same threshold.
      wt = int'($urandom_range(0, 1023));
      send(rnd(), rnd(), wt, 1);
      send(rnd(), rnd(), wt, 0);
      for (int i = 0; i < 6; i++) begin
         a = rnd(); b = rnd();
         if (i % 2 == 1) a = a & rnd() & rnd();            // sparse differences
         send(a, b, int'($urandom_range(0, 1023)), 0);
      end
      wt = 0;
      while ((inflight || q.size() != 0) && wt < 5000) begin @(posedge clk_i); wt++; end
      if (wt >= 5000) chk("drain_timeout", 0, 1);
      repeat (3) @(posedge clk_i);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish (%0d checks, %0d failures)", n_chk, n_fail);
      $fatal(1, "watchdog");
   end
endmodule
